control_unit: RTL

- Multi-cycle FSM controller for the K&S processor.
- Consumes `decoded_instruction` and the registered flags from the datapath.
- Drives every datapath control strobe (`branch`, `pc_enable`, `ir_enable`, `addr_sel`, `c_sel`, `operation`, `write_reg_enable`, `flags_reg_enable`), plus the RAM write strobe and the halt indication.
- Pairs one-to-one with the datapath at processor top level.

---
 rtl/control_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// K&S processor control unit: multi-cycle FSM that sequences fetch, decode and execute
// and drives every datapath strobe, the RAM write strobe and the halt indication.

package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP    = 4'd0,
    I_LOAD   = 4'd1,
    I_STORE  = 4'd2,
    I_MOVE   = 4'd3,
    I_ADD    = 4'd4,
    I_SUB    = 4'd5,
    I_AND    = 4'd6,
    I_OR     = 4'd7,
    I_BRANCH = 4'd8,
    I_BZERO  = 4'd9,
    I_BNZERO = 4'd10,
    I_BNEG   = 4'd11,
    I_BNNEG  = 4'd12,
    I_BOV    = 4'd13,
    I_BNOV   = 4'd14,
    I_HALT   = 4'd15
  } decoded_instruction_type;
endpackage

module control_unit
  import k_and_s_pkg::*;
#(
  parameter int INSTR_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic [INSTR_CNT_W-1:0]  instr_count
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_FETCH_LD,
    S_DECODE,
    S_LOAD_ADDR,
    S_LOAD_WB,
    S_STORE,
    S_ALU,
    S_BR,
    S_HALT
  } state_t;

  state_t                 state_q, state_d;
  logic [INSTR_CNT_W-1:0] instr_count_q, instr_count_d;
  logic                   retire;
  logic                   branch_taken;

  // No instruction in this ISA branches on signed overflow.
  logic unused_signed_overflow;
  assign unused_signed_overflow = signed_overflow;

  always_comb begin
    branch_taken = 1'b0;
    unique case (decoded_instruction)
      I_BRANCH: branch_taken = 1'b1;
      I_BZERO:  branch_taken = zero_op;
      I_BNZERO: branch_taken = ~zero_op;
      I_BNEG:   branch_taken = neg_op;
      I_BNNEG:  branch_taken = ~neg_op;
      I_BOV:    branch_taken = unsigned_overflow;
      I_BNOV:   branch_taken = ~unsigned_overflow;
      default:  branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:     state_d = S_FETCH_LD;
      S_FETCH_LD:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (decoded_instruction)
          I_LOAD:                                    state_d = S_LOAD_ADDR;
          I_STORE:                                   state_d = S_STORE;
          I_MOVE, I_ADD, I_SUB, I_AND, I_OR:         state_d = S_ALU;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
          I_BNNEG, I_BOV, I_BNOV:                    state_d = S_BR;
          I_HALT:                                    state_d = S_HALT;
          default:                                   state_d = S_FETCH;
        endcase
      end
      S_LOAD_ADDR: state_d = S_LOAD_WB;
      S_LOAD_WB:   state_d = S_FETCH;
      S_STORE:     state_d = S_FETCH;
      S_ALU:       state_d = S_FETCH;
      S_BR:        state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  // FETCH is only ever re-entered at the end of an instruction, so any such entry retires one.
  assign retire = (state_d == S_FETCH) && (state_q != S_FETCH);

  always_comb begin
    instr_count_d = instr_count_q;
    if (retire && (instr_count_q != {INSTR_CNT_W{1'b1}})) begin
      instr_count_d = instr_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Strobes are a pure decode of the state so an async reset drops them without a clock edge.
  always_comb begin
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    unique case (state_q)
      S_FETCH:     addr_sel = 1'b0;
      S_FETCH_LD:  ir_enable = 1'b1;
      S_DECODE:    pc_enable = 1'b1;
      S_LOAD_ADDR: addr_sel = 1'b1;
      S_LOAD_WB: begin
        addr_sel         = 1'b1;
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
      end
      S_STORE: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
      end
      S_ALU: begin
        write_reg_enable = 1'b1;
        unique case (decoded_instruction)
          I_ADD: begin operation = 2'b00; flags_reg_enable = 1'b1; end
          I_SUB: begin operation = 2'b11; flags_reg_enable = 1'b1; end
          I_AND: begin operation = 2'b01; flags_reg_enable = 1'b1; end
          I_OR:  begin operation = 2'b10; flags_reg_enable = 1'b1; end
          I_MOVE: operation = 2'b10;
          default: operation = 2'b00;
        endcase
      end
      S_BR: begin
        if (branch_taken) begin
          addr_sel  = 1'b1;
          branch    = 1'b1;
          pc_enable = 1'b1;
        end
      end
      S_HALT:  halt = 1'b1;
      default: halt = 1'b0;
    endcase
  end

  assign instr_count = instr_count_q;

endmodule
